byte_out_fifo: RTL and testbench

- Downstream stage of the nibble-assembly path (sequencer + data_path).
- Captures each completed 8-bit word from data_path, qualified by the sequencer's op_valid, into a small FIFO.
- Presents stored words to the next consumer over a valid/ready handshake.
- Decouples the 2-nibble assembly rate from consumer back-pressure and flags lost words.

---
 rtl/byte_out_fifo.sv | 80 ++++++++
 tb/tb_byte_out_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_out_fifo.sv
// Output FIFO for assembled bytes: one push per op_valid rising edge,
// first-word fall-through read side with a sticky overflow flag.
module byte_out_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          op_valid,
    input  logic [7:0]    DATA_IN,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_op_q;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_wr_en;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = op_valid & ~r_op_q;
    assign w_pop   = ~w_empty & rd_ready;
    // A pop on a full FIFO frees the slot the push lands in.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_op_q   <= 1'b0;
        end else begin
            r_op_q <= op_valid;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && !w_wr_en) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; only valid entries are ever observed.
    always_ff @(posedge CLK) begin
        if (!RESET && w_wr_en) begin
            r_mem[r_wr_ptr] <= DATA_IN;
        end
    end

    assign rd_valid = ~w_empty;
    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_byte_out_fifo.sv
// Self-checking bench for byte_out_fifo: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_byte_out_fifo;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       op_valid = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_pass = 0;
    int n_total = 0;

    bit [7:0] mq[$];
    bit       m_ovf = 1'b0;
    bit       m_prev = 1'b0;

    byte_out_fifo #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .op_valid (op_valid),
        .DATA_IN  (DATA_IN),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    // Apply inputs for one cycle and advance the reference model.
    task automatic tick(input bit rst, input bit op,
                        input bit [7:0] d, input bit rdy);
        bit push;
        RESET    = rst;
        op_valid = op;
        DATA_IN  = d;
        rd_ready = rdy;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b0;
        end else begin
            push = op && !m_prev;
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else m_ovf = 1'b1;
            end
            m_prev = op;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input bit [7:0] d);
        tick(1'b0, 1'b1, d, 1'b0);
        tick(1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        n_total++;
        if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid);
        else n_pass++;
        n_total++;
        if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty);
        else n_pass++;
        n_total++;
        if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow);
        else n_pass++;
        n_total++;
        if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full);
        else n_pass++;
    endtask

    task automatic test_single;
        tick(1'b0, 1'b1, 8'hFA, 1'b0);
        n_total++;
        if (rd_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", rd_valid);
        else n_pass++;
        n_total++;
        if (rd_data !== 8'hFA) $display("FAIL single_data got %h exp fa", rd_data);
        else n_pass++;
        n_total++;
        if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count);
        else n_pass++;
        tick(1'b0, 1'b0, 8'hFA, 1'b1);
        n_total++;
        if (empty !== 1'b1 || count !== 3'd0)
            $display("FAIL single_pop got empty=%b count=%0d exp 1/0", empty, count);
        else n_pass++;
    endtask

    task automatic test_held;
        repeat (4) tick(1'b0, 1'b1, 8'hD5, 1'b0);
        n_total++;
        if (count !== 3'd1) $display("FAIL held_count got %0d exp 1", count);
        else n_pass++;
        n_total++;
        if (rd_data !== 8'hD5) $display("FAIL held_data got %h exp d5", rd_data);
        else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        n_total++;
        if (empty !== 1'b1) $display("FAIL held_drain got empty=%b exp 1", empty);
        else n_pass++;
    endtask

    task automatic test_fill_overflow;
        bit [7:0] exp_w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (exp_w[i]) push_word(exp_w[i]);
        n_total++;
        if (full !== 1'b1 || count !== 3'd4)
            $display("FAIL fill_full got full=%b count=%0d exp 1/4", full, count);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL fill_no_ovf got %b exp 0", overflow);
        else n_pass++;
        push_word(8'h55);
        n_total++;
        if (overflow !== 1'b1 || count !== 3'd4)
            $display("FAIL ovf_set got ovf=%b count=%0d exp 1/4", overflow, count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rd_data !== exp_w[i])
                $display("FAIL drain_order[%0d] got %h exp %h", i, rd_data, exp_w[i]);
            else n_pass++;
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
        n_total++;
        if (empty !== 1'b1 || overflow !== 1'b1)
            $display("FAIL drain_end got empty=%b ovf=%b exp 1/1", empty, overflow);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        n_total++;
        if (count !== 3'd3) $display("FAIL mid_pre_count got %0d exp 3", count);
        else n_pass++;
        tick(1'b1, 1'b1, 8'hA4, 1'b0);
        n_total++;
        if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0)
            $display("FAIL mid_reset got count=%0d empty=%b ovf=%b exp 0/1/0",
                     count, empty, overflow);
        else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        n_total++;
        if (empty !== 1'b1) $display("FAIL mid_no_store got empty=%b exp 1", empty);
        else n_pass++;
        // op_valid high right after reset is a fresh edge.
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'h3C, 1'b0);
        n_total++;
        if (count !== 3'd1 || rd_data !== 8'h3C)
            $display("FAIL post_reset_push got count=%0d data=%h exp 1/3c",
                     count, rd_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit [7:0] exp_w [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        tick(1'b0, 1'b1, 8'h66, 1'b1);
        n_total++;
        if (count !== 3'd4 || full !== 1'b1)
            $display("FAIL b2b_count got count=%0d full=%b exp 4/1", count, full);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", overflow);
        else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rd_data !== exp_w[i])
                $display("FAIL b2b_order[%0d] got %h exp %h", i, rd_data, exp_w[i]);
            else n_pass++;
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
        n_total++;
        if (empty !== 1'b1) $display("FAIL b2b_empty got %b exp 1", empty);
        else n_pass++;
    endtask

    task automatic test_random;
        bit       op;
        bit       rdy;
        bit       rst;
        bit [7:0] d;
        int       errs;
        d = 8'h00;
        op = 1'b0;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            if (!op) d = 8'($urandom);
            op  = ($urandom_range(0, 2) != 0);
            rdy = (c < 300) ? ($urandom_range(0, 3) == 0)
                            : ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick(rst, op, d, rdy);
            n_total++;
            if (count !== 3'(mq.size()) || rd_valid !== (mq.size() > 0) ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                overflow !== m_ovf ||
                (mq.size() > 0 && rd_data !== mq[0])) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand[%0d] got cnt=%0d v=%b f=%b e=%b o=%b d=%h exp cnt=%0d o=%b d=%h",
                             c, count, rd_valid, full, empty, overflow, rd_data,
                             mq.size(), m_ovf, (mq.size() > 0) ? mq[0] : 8'h00);
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_fill_overflow();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
